// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared data-memory port. Grants are registered.
// Only the current owner's live request opens the memory-side strobes.
module mem_arbiter #(
  parameter int NUM_M     = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*32-1:0] m_addr_i,
  input  logic [NUM_M*32-1:0] m_wdata_i,
  output logic [NUM_M-1:0]    m_gnt_o,
  output logic [31:0]         m_rdata_o,
  output logic                s_we_o,
  output logic [31:0]         s_waddr_o,
  output logic [31:0]         s_wdata_o,
  output logic [31:0]         s_raddr_o,
  input  logic [31:0]         s_rdata_i,
  output logic                hold_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] last, last_n;
  logic [IW-1:0] winner;
  logic [8:0]    burst_cnt, burst_cnt_n;
  logic          win_found;
  logic          any_req;
  logic          others_req;
  logic          burst_full;
  logic          xfer;

  // The most recent owner is scanned last, so it has the lowest priority.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      if (!win_found && m_req_i[(int'(last) + k) % NUM_M]) begin
        win_found = 1'b1;
        winner    = IW'((int'(last) + k) % NUM_M);
      end
    end
  end

  assign any_req    = |m_req_i;
  assign others_req = |(m_req_i & ~m_gnt_o);
  assign burst_full = (burst_cnt == 9'(MAX_BURST));

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    last_n      = last;
    burst_cnt_n = burst_cnt;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n     = OWN;
          owner_n     = winner;
          last_n      = winner;
          burst_cnt_n = 9'd1;
        end
      end
      OWN: begin
        if (!m_req_i[owner]) begin
          if (win_found) begin
            owner_n     = winner;
            last_n      = winner;
            burst_cnt_n = 9'd1;
          end else begin
            state_n = IDLE;
          end
        end else if (burst_full && others_req) begin
          owner_n     = winner;
          last_n      = winner;
          burst_cnt_n = 9'd1;
        end else if (!burst_full) begin
          burst_cnt_n = burst_cnt + 9'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Reset puts last at the top index so master 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= IW'(NUM_M - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      last      <= last_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  assign m_gnt_o = (state == OWN) ? (NUM_M'(1) << owner) : '0;
  assign xfer    = (state == OWN) && m_req_i[owner];

  assign s_we_o    = xfer && m_we_i[owner];
  assign s_waddr_o = xfer ? m_addr_i[32*int'(owner) +: 32] : 32'd0;
  assign s_raddr_o = xfer ? m_addr_i[32*int'(owner) +: 32] : 32'd0;
  assign s_wdata_o = xfer ? m_wdata_i[32*int'(owner) +: 32] : 32'd0;
  assign m_rdata_o = s_rdata_i;
  assign hold_o    = m_req_i[0] & ~m_gnt_o[0];

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single data-memory port among NUM_M bus masters: master 0 is the core's load/store port, and the others are the debug/download master and DMA. It sits between the masters and the RAM. It registers a grant, muxes the owner's address, data and write-enable onto the memory port, and caps burst length so no master starves the others. It also drives a hold request to the core's pipeline control whenever master 0 is requesting but not granted.

## Interface
Parameters:
- NUM_M, 3: number of masters (2..8); index 0 is the core.
- MAX_BURST, 16: maximum consecutive granted cycles before forced re-arbitration when others wait (2..256).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low (sampled on rising clk edge).
- m_req_i  in  NUM_M  per-master request, level, held for the whole access sequence.
- m_we_i  in  NUM_M  per-master write enable, valid with req.
- m_addr_i  in  NUM_M*32  per-master address; master i occupies bits [32i+31:32i].
- m_wdata_i  in  NUM_M*32  per-master write data, same packing.
- m_gnt_o  out  NUM_M  registered one-hot grant.
- m_rdata_o  out  32  read data, s_rdata_i broadcast to all masters.
- s_we_o  out  1  memory write enable.
- s_waddr_o  out  32  memory write address.
- s_wdata_o  out  32  memory write data.
- s_raddr_o  out  32  memory read address.
- s_rdata_i  in  32  memory read data (combinational, same cycle as s_raddr_o).
- hold_o  out  1  pause request to the core pipeline control: m_req_i[0] & ~m_gnt_o[0].

## Operation
- State: owner (index), busy flag, last (index of the most recent owner), burst counter (8 bit).
  - Two states: IDLE (busy=0, m_gnt_o=0) and OWN (busy=1, m_gnt_o one-hot at owner).
- Selection: the winner is the first requesting master scanning last+1, last+2, … wrapping modulo NUM_M. last itself is lowest priority.
- IDLE:
  - If any m_req_i is set, go to OWN with the selected winner. Set last=winner and counter=1.
  - Otherwise stay in IDLE.
- OWN, checked in this order:
  - Owner's req is low: release. If other requests are pending, hand over directly to the selected winner with counter=1, with no idle cycle. Otherwise go to IDLE.
  - counter==MAX_BURST and any other master is requesting: forced handover to the selected winner (the owner excluded, being last). Counter=1.
  - Else: stay and increment the counter, saturating at MAX_BURST. With no competition, the owner keeps the port indefinitely.
- Transfer cycle for master i: m_gnt_o[i] & m_req_i[i].
  - s_raddr_o = owner addr.
  - s_waddr_o = owner addr.
  - s_wdata_o = owner wdata.
  - s_we_o = owner we.
- No transfer cycle: s_we_o=0, s_waddr_o/s_raddr_o/s_wdata_o=0. A granted master that has dropped its req never writes.
- m_rdata_o = s_rdata_i unconditionally; only the owner may consume it.
- Width rules: 32-bit datapath, no address translation. The counter compares against MAX_BURST as an unsigned 8-bit value (MAX_BURST=256 is encoded as 0 with wrap-compare; implement the counter as 9 bits if simpler).

## Timing
- Reset (rst_n=0 at an edge): m_gnt_o=0, busy=0, last=NUM_M-1 (so master 0 wins first), counter=0.
  - s_we_o=0 and all s_* addresses/data are 0.
  - hold_o follows m_req_i[0] combinationally, so it is 1 if the core requests during reset.
  - Reset mid-burst drops the grant at that edge; no partial write is issued after it.
- Grant latency: req rising in cycle N → m_gnt_o high from cycle N+1 (if the port is free or released). The first transfer happens in cycle N+1.
- Release: owner drops req in cycle N → new grant visible in N+1. The port is idle in cycle N (req low ⇒ no transfer).
- Forced handover: with competition, the owner holds grant for exactly MAX_BURST cycles. The next master's grant appears in the following cycle.
- Simultaneous requests from IDLE: resolved purely by round-robin from last.
- hold_o is combinational from m_req_i[0] and registered m_gnt_o[0]; zero-cycle path to the pipeline control.
- m_gnt_o is always one-hot or zero, never multi-hot.

## Test plan
- Reset then single request: after reset, m_req_i=3'b010 at cycle 0 → m_gnt_o=3'b010 at cycle 1. With we=1, addr=0x100, wdata=0xDEADBEEF: s_we_o=1, s_waddr_o=0x100, s_wdata_o=0xDEADBEEF. hold_o=0 throughout.
- Simultaneous start: reset, then m_req_i=3'b111 held → grants 0,1,2,0 each lasting MAX_BURST=16 cycles. hold_o=1 exactly while master 0 is not granted.
- Early release handover: master 1 owns and master 2 is requesting. Master 1 drops req at cycle N → s_we_o=0 at N, m_gnt_o=3'b100 at N+1, no IDLE cycle.
- Uncontested long burst: only master 2 requests for 40 cycles → grant stays 3'b100 for all 40 cycles; counter saturates with no forced release.
- Reset mid-burst: master 1 is writing; rst_n=0 for one edge → m_gnt_o=0 and s_we_o=0 at the next cycle. After rst_n returns with req still high, master 1 is regranted (last=NUM_M-1, no lower index requesting).
- Read path: master 0 granted, we=0, addr=0x40, s_rdata_i=0x12345678 → s_raddr_o=0x40 and m_rdata_o=0x12345678 in the same cycle, s_we_o=0.
